// File: rtl/bcd_arb_pkg.sv
// Shared types and defaults for the BCD converter arbiter: FSM state encoding,
// default parameter values, and the requester-id width helper.
package bcd_arb_pkg;

  localparam int unsigned N_REQ_DEF      = 4;
  localparam int unsigned BITS_IN_DEF    = 16;
  localparam int unsigned BCD_DIGITS_DEF = 5;
  localparam int unsigned TIMEOUT_DEF    = 40;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  // Keeps the id bus at least one bit wide for degenerate requester counts.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts at ptr_i and wraps;
// returns a one-hot grant, the winner index and whether anyone requested.
module rr_arbiter #(
  parameter int unsigned N_REQ_PP    = 4,
  parameter int unsigned ID_WIDTH_PP = 2
) (
  input  logic [N_REQ_PP-1:0]    req_i,
  input  logic [ID_WIDTH_PP-1:0] ptr_i,
  output logic [N_REQ_PP-1:0]    grant_o,
  output logic [ID_WIDTH_PP-1:0] idx_o,
  output logic                   any_o
);

  logic [2*N_REQ_PP-1:0] dbl;
  logic [N_REQ_PP-1:0]   rot;

  always_comb begin
    dbl     = {req_i, req_i} >> ptr_i;
    rot     = dbl[N_REQ_PP-1:0];
    idx_o   = '0;
    any_o   = 1'b0;
    grant_o = '0;
    // rot[i] is requester (ptr + i) mod N, so the first set bit is the winner
    for (int unsigned i = 0; i < N_REQ_PP; i++) begin
      if (!any_o && rot[i]) begin
        any_o = 1'b1;
        idx_o = ID_WIDTH_PP'((32'(ptr_i) + i) % N_REQ_PP);
      end
    end
    for (int unsigned k = 0; k < N_REQ_PP; k++) begin
      grant_o[k] = any_o && (ID_WIDTH_PP'(k) == idx_o);
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one serial binary_to_bcd converter among several requesters: arbitrates,
// sequences the start/done handshake, and returns id-tagged results or a watchdog abort.
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int unsigned N_REQ_PP          = N_REQ_DEF,
  parameter int unsigned BITS_IN_PP        = BITS_IN_DEF,
  parameter int unsigned BCD_DIGITS_OUT_PP = BCD_DIGITS_DEF,
  parameter int unsigned TIMEOUT_PP        = TIMEOUT_DEF,
  parameter int unsigned ID_WIDTH_PP       = id_width(N_REQ_PP)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [N_REQ_PP-1:0]              req_i,
  input  logic [N_REQ_PP*BITS_IN_PP-1:0]   dat_i,
  output logic [N_REQ_PP-1:0]              ack_o,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [ID_WIDTH_PP-1:0]           rsp_id_o,
  output logic [4*BCD_DIGITS_OUT_PP-1:0]   rsp_bcd_o,
  output logic                             rsp_err_o,
  output logic                             conv_start_o,
  output logic                             conv_ce_o,
  output logic [BITS_IN_PP-1:0]            conv_dat_o,
  input  logic                             conv_done_i,
  input  logic [4*BCD_DIGITS_OUT_PP-1:0]   conv_bcd_i
);

  localparam int unsigned BCD_W = 4 * BCD_DIGITS_OUT_PP;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_PP + 1);
  localparam logic [WD_W-1:0]        WD_MAX  = WD_W'(TIMEOUT_PP);
  localparam logic [ID_WIDTH_PP-1:0] ID_LAST = ID_WIDTH_PP'(N_REQ_PP - 1);

  state_t                  state_q, state_d;
  logic [ID_WIDTH_PP-1:0]  ptr_q, ptr_d;
  logic [ID_WIDTH_PP-1:0]  id_q, id_d;
  logic [BITS_IN_PP-1:0]   dat_q, dat_d;
  logic [N_REQ_PP-1:0]     ack_q, ack_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d;
  logic                    err_q, err_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic [WD_W-1:0]         wd_inc;

  logic [N_REQ_PP-1:0]     grant;
  logic [ID_WIDTH_PP-1:0]  win_idx;
  logic                    win_any;

  rr_arbiter #(
    .N_REQ_PP    (N_REQ_PP),
    .ID_WIDTH_PP (ID_WIDTH_PP)
  ) u_rr (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    dat_d   = dat_q;
    ack_d   = '0;
    bcd_d   = bcd_q;
    err_d   = err_q;
    wd_d    = wd_q;
    wd_inc  = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        // conv_done_i gate covers a converter still busy from before a reset
        if (win_any && conv_done_i) begin
          id_d  = win_idx;
          ack_d = grant;
          ptr_d = (win_idx == ID_LAST) ? '0 : win_idx + 1'b1;
          for (int unsigned k = 0; k < N_REQ_PP; k++) begin
            if (grant[k]) dat_d = dat_i[k*BITS_IN_PP +: BITS_IN_PP];
          end
          state_d = START;
        end
      end
      START: begin
        wd_d    = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        wd_d = wd_inc;
        if (wd_inc == WD_MAX) begin
          bcd_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (!conv_done_i) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        wd_d = wd_inc;
        if (conv_done_i) begin
          bcd_d   = conv_bcd_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_inc == WD_MAX) begin
          bcd_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      dat_q   <= '0;
      ack_q   <= '0;
      bcd_q   <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      bcd_q   <= bcd_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  assign ack_o        = ack_q;
  assign conv_start_o = (state_q == START);
  assign conv_ce_o    = (state_q == START) || (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
  assign conv_dat_o   = dat_q;
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_id_o     = id_q;
  assign rsp_bcd_o    = bcd_q;
  assign rsp_err_o    = err_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a behavioural serial converter model
// that can be told to hang (never raise done) or to release.
module tb_bcd_conv_arbiter;

  localparam int unsigned CONV_LAT = 17;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:0]  req_i;
  logic [63:0] dat_i;
  logic [3:0]  ack_o;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [1:0]  rsp_id_o;
  logic [19:0] rsp_bcd_o;
  logic        rsp_err_o;
  logic        conv_start_o;
  logic        conv_ce_o;
  logic [15:0] conv_dat_o;
  logic        conv_done_i = 1'b1;
  logic [19:0] conv_bcd_i  = '0;

  logic        conv_hang    = 1'b0;
  logic        conv_release = 1'b0;
  int          busy = 0;
  logic [19:0] pend = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_conv_arbiter #(
    .N_REQ_PP          (4),
    .BITS_IN_PP        (16),
    .BCD_DIGITS_OUT_PP (5),
    .TIMEOUT_PP        (40),
    .ID_WIDTH_PP       (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .dat_i        (dat_i),
    .ack_o        (ack_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_bcd_o    (rsp_bcd_o),
    .rsp_err_o    (rsp_err_o),
    .conv_start_o (conv_start_o),
    .conv_ce_o    (conv_ce_o),
    .conv_dat_o   (conv_dat_o),
    .conv_done_i  (conv_done_i),
    .conv_bcd_i   (conv_bcd_i)
  );

  function automatic logic [19:0] to_bcd(input logic [15:0] v);
    logic [19:0] r;
    int unsigned x;
    x = v;
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Converter model: done_o low while busy, result presented when done rises.
  always @(posedge clk) begin
    if (conv_release) begin
      conv_done_i <= 1'b1;
    end else if (conv_start_o && conv_ce_o) begin
      conv_done_i <= 1'b0;
      busy        <= conv_hang ? 0 : CONV_LAT;
      pend        <= to_bcd(conv_dat_o);
    end else if (busy == 1) begin
      busy        <= 0;
      conv_done_i <= 1'b1;
      conv_bcd_i  <= pend;
    end else if (busy > 1) begin
      busy <= busy - 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_dat(input int k, input logic [15:0] v);
    dat_i[k*16 +: 16] = v;
  endtask

  task automatic wait_ack(input logic [3:0] exp, input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack_o == 4'b0 && n < 200);
    check({tag, "_ack"}, 64'(ack_o), 64'(exp));
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid_o && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic serve(input logic [3:0] exp_ack, input logic [1:0] exp_id,
                       input logic [19:0] exp_bcd, input logic exp_err,
                       input string tag, output int n_ack, output int n_rsp);
    wait_ack(exp_ack, tag, n_ack);
    req_i = req_i & ~exp_ack;
    wait_rsp(n_rsp);
    check({tag, "_valid"}, 64'(rsp_valid_o), 64'(1));
    check({tag, "_id"},    64'(rsp_id_o),    64'(exp_id));
    check({tag, "_bcd"},   64'(rsp_bcd_o),   64'(exp_bcd));
    check({tag, "_err"},   64'(rsp_err_o),   64'(exp_err));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [3:0]  exp_ack_t [4];
    logic [19:0] exp_bcd_t [4];
    int na, nr;

    rst_i = 1'b1;
    req_i = '0;
    dat_i = '0;
    rsp_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", 64'({ack_o, conv_start_o, conv_ce_o, rsp_valid_o, rsp_err_o,
                             rsp_id_o, rsp_bcd_o, conv_dat_o}), 64'(0));
    rst_i = 1'b0;
    @(negedge clk);
    check("idle_no_ack", 64'(ack_o), 64'(0));

    // All four requesting from pointer 0: served 0,1,2,3 back to back
    set_dat(0, 16'd65535);
    set_dat(1, 16'd0);
    set_dat(2, 16'd9);
    set_dat(3, 16'd100);
    exp_ack_t = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_bcd_t = '{20'h65535, 20'h00000, 20'h00009, 20'h00100};
    req_i = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      serve(exp_ack_t[j], 2'(j), exp_bcd_t[j], 1'b0, $sformatf("rr%0d", j), na, nr);
      if (j > 0) check($sformatf("rr%0d_b2b", j), 64'(na), 64'(2));
    end

    // Single request, ack pulses exactly once
    @(negedge clk);
    set_dat(0, 16'd1234);
    req_i = 4'b0001;
    wait_ack(4'b0001, "single", na);
    req_i = '0;
    @(negedge clk);
    check("single_ack_once", 64'(ack_o), 64'(0));
    wait_rsp(nr);
    check("single_id",  64'(rsp_id_o),  64'(0));
    check("single_bcd", 64'(rsp_bcd_o), 64'(20'h01234));
    check("single_err", 64'(rsp_err_o), 64'(0));
    @(negedge clk);
    check("single_valid_drop", 64'(rsp_valid_o), 64'(0));

    // Pointer now 1: 0101 grants 2 before 0
    set_dat(0, 16'd7);
    set_dat(2, 16'd4321);
    req_i = 4'b0101;
    serve(4'b0100, 2'd2, 20'h04321, 1'b0, "ptr_a", na, nr);
    serve(4'b0001, 2'd0, 20'h00007, 1'b0, "ptr_b", na, nr);

    // Consumer stalls: response held, no grant while in RESP
    @(negedge clk);
    rsp_ready_i = 1'b0;
    set_dat(3, 16'd9999);
    req_i = 4'b1000;
    wait_ack(4'b1000, "hold", na);
    req_i = 4'b0000;
    wait_rsp(nr);
    set_dat(1, 16'd50);
    req_i = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("hold_c%0d", c), 64'({rsp_valid_o, rsp_id_o, rsp_bcd_o, ack_o}),
            64'({1'b1, 2'd3, 20'h09999, 4'b0000}));
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    check("hold_release", 64'(rsp_valid_o), 64'(0));
    serve(4'b0010, 2'd1, 20'h00050, 1'b0, "after_hold", na, nr);

    // Converter hangs: watchdog aborts with err and zero result
    @(negedge clk);
    conv_hang = 1'b1;
    set_dat(0, 16'd42);
    req_i = 4'b0001;
    serve(4'b0001, 2'd0, 20'h00000, 1'b1, "wdog", na, nr);
    check("wdog_latency", 64'(nr >= 40 && nr <= 42), 64'(1));
    @(negedge clk);
    conv_hang = 1'b0;
    conv_release = 1'b1;
    @(negedge clk);
    conv_release = 1'b0;
    set_dat(0, 16'd808);
    req_i = 4'b0001;
    serve(4'b0001, 2'd0, 20'h00808, 1'b0, "post_wdog", na, nr);

    // Reset while converter busy: outputs clear, no grant until done rises
    @(negedge clk);
    set_dat(1, 16'd555);
    req_i = 4'b0010;
    wait_ack(4'b0010, "rst_mid", na);
    repeat (5) @(negedge clk);
    rst_i = 1'b1;
    #1;
    check("rst_mid_outs", 64'({ack_o, conv_start_o, conv_ce_o, rsp_valid_o, rsp_err_o,
                               rsp_id_o, rsp_bcd_o, conv_dat_o}), 64'(0));
    @(negedge clk);
    rst_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("rst_gate_c%0d", c), 64'(ack_o), 64'(0));
    end
    serve(4'b0010, 2'd1, 20'h00555, 1'b0, "rst_recover", na, nr);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
